// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-master Wishbone arbiter sharing one QSPI memory port
// between the CPU instruction bus (imem) and data bus (dmem).
// The grant is registered and held for the whole transfer. A DONE bubble
// separates transfers, and a dmem aging counter keeps back-to-back
// fetches from starving dmem.
// Optional feature: define WB_MEM_ARB_TIMEOUT_EN to build the slave-ack
// timeout. Without it, timeout_o is tied low and a grant waits forever.
module wb_mem_arbiter #(
    parameter int AGE_MAX = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_stb_i,
    input  logic [31:0] i_adr_i,
    output logic [31:0] i_dat_o,
    output logic        i_ack_o,
    input  logic        d_stb_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_adr_i,
    input  logic [31:0] d_dat_i,
    output logic [31:0] d_dat_o,
    output logic        d_ack_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_age;
    logic        w_ageFull;
    logic        w_inGrant;
    logic        w_timeoutHit;
    logic [31:0] w_rdata;

    assign w_ageFull = (r_age == 4'(AGE_MAX));
    assign w_inGrant = (r_state == GNT_I) || (r_state == GNT_D);

`ifdef WB_MEM_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tmoCnt;
    logic          r_timeout;

    // A silent slave is declared dead once the counter reaches TIMEOUT.
    // A real ack in the same cycle still wins.
    assign w_timeoutHit = w_inGrant && !m_ack_i && (r_tmoCnt == TW'(TIMEOUT));
    assign timeout_o    = r_timeout;

    // Count grant cycles without an ack. The count clears outside a grant,
    // so every grant entry starts from zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmoCnt <= '0;
        end else if (!w_inGrant) begin
            r_tmoCnt <= '0;
        end else if (!m_ack_i && !w_timeoutHit) begin
            r_tmoCnt <= r_tmoCnt + TW'(1);
        end
    end

    // Once set, the timeout flag stays set until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else if (w_timeoutHit) begin
            r_timeout <= 1'b1;
        end
    end
`else
    assign w_timeoutHit = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // State register. Reset returns to IDLE at once, which drops m_stb_o
    // mid-transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Arbitration and transfer sequencing. A grant exits to DONE on an ack
    // or a timeout, and back to IDLE if its master aborts.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_stb_i && d_stb_i) begin
                    w_next = w_ageFull ? GNT_D : GNT_I;
                end else if (i_stb_i) begin
                    w_next = GNT_I;
                end else if (d_stb_i) begin
                    w_next = GNT_D;
                end
            end
            GNT_I: begin
                if (m_ack_i || w_timeoutHit) begin
                    w_next = DONE;
                end else if (!i_stb_i) begin
                    w_next = IDLE;
                end
            end
            GNT_D: begin
                if (m_ack_i || w_timeoutHit) begin
                    w_next = DONE;
                end else if (!d_stb_i) begin
                    w_next = IDLE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Age of the pending dmem request. It counts while dmem waits outside
    // its own grant, saturates at AGE_MAX, and clears when dmem is granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_age <= 4'd0;
        end else if ((w_next == GNT_D) && (r_state != GNT_D)) begin
            r_age <= 4'd0;
        end else if (d_stb_i && (r_state != GNT_D) && !w_ageFull) begin
            r_age <= r_age + 4'd1;
        end
    end

    // Read data goes to both masters; only the ack is steered. A timed-out
    // transfer returns all ones.
    assign w_rdata = w_timeoutHit ? 32'hFFFF_FFFF : m_dat_i;
    assign i_dat_o = w_rdata;
    assign d_dat_o = w_rdata;

    // Memory-side signals and ack steering are decoded combinationally
    // from the registered grant.
    always_comb begin
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_be_o  = 4'h0;
        m_adr_o = i_adr_i;
        m_dat_o = d_dat_i;
        gnt_o   = 2'b00;
        i_ack_o = 1'b0;
        d_ack_o = 1'b0;
        case (r_state)
            GNT_I: begin
                m_stb_o = i_stb_i;
                m_be_o  = 4'hF;
                gnt_o   = 2'b01;
                i_ack_o = m_ack_i || w_timeoutHit;
            end
            GNT_D: begin
                m_stb_o = d_stb_i;
                m_we_o  = d_we_i;
                m_be_o  = d_be_i;
                m_adr_o = d_adr_i;
                gnt_o   = 2'b10;
                d_ack_o = m_ack_i || w_timeoutHit;
            end
            default: begin
                m_stb_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed testbench for wb_mem_arbiter (AGE_MAX=4, TIMEOUT=8).
// Inputs change 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
module tb_wb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iStb;
    logic [31:0] iAdr;
    logic [31:0] iDat;
    logic        iAck;
    logic        dStb;
    logic        dWe;
    logic [3:0]  dBe;
    logic [31:0] dAdr;
    logic [31:0] dDatIn;
    logic [31:0] dDat;
    logic        dAck;
    logic        mStb;
    logic        mWe;
    logic [3:0]  mBe;
    logic [31:0] mAdr;
    logic [31:0] mDat;
    logic [31:0] mDatIn;
    logic        mAck;
    logic [1:0]  gnt;
    logic        timeoutOut;

    // In auto mode the memory acks in the same cycle that it sees a strobe.
    logic        autoAck;
    logic        ackManual;
    assign mAck = autoAck ? mStb : ackManual;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(.AGE_MAX(4), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_stb_i(iStb), .i_adr_i(iAdr), .i_dat_o(iDat), .i_ack_o(iAck),
        .d_stb_i(dStb), .d_we_i(dWe), .d_be_i(dBe), .d_adr_i(dAdr),
        .d_dat_i(dDatIn), .d_dat_o(dDat), .d_ack_o(dAck),
        .m_stb_o(mStb), .m_we_o(mWe), .m_be_o(mBe), .m_adr_o(mAdr),
        .m_dat_o(mDat), .m_dat_i(mDatIn), .m_ack_i(mAck),
        .gnt_o(gnt), .timeout_o(timeoutOut)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; iStb = 0; iAdr = 0; dStb = 0; dWe = 0; dBe = 0;
        dAdr = 0; dDatIn = 0; mDatIn = 0; autoAck = 0; ackManual = 0;
        repeat (2) @(posedge clk);
        sample();
        tests++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); end
        tests++; if ({mStb, mWe, mBe} !== 6'b0) begin errors++; $display("[TB] FAIL reset_mctl: got %b expected 000000", {mStb, mWe, mBe}); end
        tests++; if (mAdr !== 32'h0) begin errors++; $display("[TB] FAIL reset_madr: got %h expected 0", mAdr); end
        tests++; if ({iAck, dAck, timeoutOut} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {iAck, dAck, timeoutOut}); end
        tests++; if (dut.r_age !== 4'd0) begin errors++; $display("[TB] FAIL reset_age: got %0d expected 0", dut.r_age); end
        rst = 1'b0;
    endtask

    task automatic test_imem_read();
        tick(); iStb = 1; iAdr = 32'h0000_0100;
        sample();
        tests++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL imem_latency: got %b expected 00", gnt); end
        tick(); sample();
        tests++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL imem_gnt: got %b expected 01", gnt); end
        tests++; if ({mStb, mWe, mBe} !== 6'b101111) begin errors++; $display("[TB] FAIL imem_mctl: got %b expected 101111", {mStb, mWe, mBe}); end
        tests++; if (mAdr !== 32'h0000_0100) begin errors++; $display("[TB] FAIL imem_madr: got %h expected 00000100", mAdr); end
        tick(); sample();
        tests++; if (iAck !== 1'b0) begin errors++; $display("[TB] FAIL imem_noack: got %b expected 0", iAck); end
        tick(); ackManual = 1; mDatIn = 32'h0000_0013;
        sample();
        tests++; if ({iAck, dAck} !== 2'b10) begin errors++; $display("[TB] FAIL imem_ack: got %b expected 10", {iAck, dAck}); end
        tests++; if (iDat !== 32'h0000_0013) begin errors++; $display("[TB] FAIL imem_data: got %h expected 00000013", iDat); end
        tick(); ackManual = 0; iStb = 0; mDatIn = 0;
        sample();
        tests++; if ({gnt, iAck} !== 3'b000) begin errors++; $display("[TB] FAIL imem_done: got %b expected 000", {gnt, iAck}); end
        tick(); sample();
        tests++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL imem_idle: got %b expected 00", gnt); end
    endtask

    task automatic test_dmem_write();
        tick(); dStb = 1; dWe = 1; dBe = 4'b0100; dAdr = 32'h1000_0004; dDatIn = 32'h00AB_0000;
        sample();
        tick(); sample();
        tests++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL dmem_gnt: got %b expected 10", gnt); end
        tests++; if ({mStb, mWe, mBe} !== 6'b110100) begin errors++; $display("[TB] FAIL dmem_mctl: got %b expected 110100", {mStb, mWe, mBe}); end
        tests++; if (mAdr !== 32'h1000_0004) begin errors++; $display("[TB] FAIL dmem_madr: got %h expected 10000004", mAdr); end
        tests++; if (mDat !== 32'h00AB_0000) begin errors++; $display("[TB] FAIL dmem_mdat: got %h expected 00ab0000", mDat); end
        tests++; if (dAck !== 1'b0) begin errors++; $display("[TB] FAIL dmem_noack: got %b expected 0", dAck); end
        tick(); ackManual = 1; mDatIn = 32'hCAFE_0000;
        sample();
        tests++; if ({iAck, dAck} !== 2'b01) begin errors++; $display("[TB] FAIL dmem_ack: got %b expected 01", {iAck, dAck}); end
        tests++; if (dDat !== 32'hCAFE_0000) begin errors++; $display("[TB] FAIL dmem_data: got %h expected cafe0000", dDat); end
        tick(); ackManual = 0; dStb = 0; dWe = 0; dBe = 0; mDatIn = 0;
        sample();
        tests++; if ({gnt, dAck} !== 3'b000) begin errors++; $display("[TB] FAIL dmem_done: got %b expected 000", {gnt, dAck}); end
        tick();
    endtask

    task automatic test_simultaneous();
        tick(); iStb = 1; dStb = 1; iAdr = 32'h0000_0200; dAdr = 32'h1000_0008; dBe = 4'hF;
        sample();
        tick(); ackManual = 1;
        sample();
        tests++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL simul_first: got %b expected 01", gnt); end
        tests++; if ({iAck, dAck} !== 2'b10) begin errors++; $display("[TB] FAIL simul_iack: got %b expected 10", {iAck, dAck}); end
        tick(); ackManual = 0; iStb = 0;
        sample();
        tests++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL simul_done: got %b expected 00", gnt); end
        tick(); sample();
        tick(); ackManual = 1;
        sample();
        tests++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL simul_second: got %b expected 10", gnt); end
        tests++; if (mAdr !== 32'h1000_0008) begin errors++; $display("[TB] FAIL simul_dadr: got %h expected 10000008", mAdr); end
        tests++; if ({iAck, dAck} !== 2'b01) begin errors++; $display("[TB] FAIL simul_dack: got %b expected 01", {iAck, dAck}); end
        tick(); ackManual = 0; dStb = 0; dBe = 0;
        sample();
        tick();
    endtask

    task automatic test_starvation();
        int iGrants = 0;
        int maxAge  = 0;
        bit found   = 0;
        logic dAckSeen = 1'b0;
        logic [3:0] ageAtGrant = 4'hF;
        iStb = 1; dStb = 1; dBe = 4'hF; autoAck = 1;
        for (int c = 0; c < 20 && !found; c++) begin
            sample();
            if (gnt == 2'b10) begin
                found = 1;
                dAckSeen = dAck;
                ageAtGrant = dut.r_age;
            end else begin
                if (gnt == 2'b01) iGrants++;
                if (int'(dut.r_age) > maxAge) maxAge = int'(dut.r_age);
                tick();
            end
        end
        tests++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL starve_found: got %b expected 1 within 20 cycles", found); end
        tests++; if (iGrants != 2) begin errors++; $display("[TB] FAIL starve_igrants: got %0d expected 2", iGrants); end
        tests++; if (maxAge != 4) begin errors++; $display("[TB] FAIL starve_agemax: got %0d expected 4", maxAge); end
        tests++; if (ageAtGrant !== 4'd0) begin errors++; $display("[TB] FAIL starve_ageclr: got %0d expected 0", ageAtGrant); end
        tests++; if (dAckSeen !== 1'b1) begin errors++; $display("[TB] FAIL starve_dack: got %b expected 1", dAckSeen); end
        tick(); autoAck = 0; iStb = 0; dStb = 0; dBe = 0;
        sample();
        tick();
    endtask

    task automatic test_abort();
        tick(); iStb = 1; iAdr = 32'h0000_0300;
        tick(); sample();
        tests++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL abort_gnt: got %b expected 01", gnt); end
        tick(); iStb = 0;
        sample();
        tests++; if ({mStb, iAck} !== 2'b00) begin errors++; $display("[TB] FAIL abort_stb: got %b expected 00", {mStb, iAck}); end
        tick(); ackManual = 1;
        sample();
        tests++; if ({gnt, iAck, dAck} !== 4'b0000) begin errors++; $display("[TB] FAIL abort_idle: got %b expected 0000", {gnt, iAck, dAck}); end
        tick(); ackManual = 0;
        sample();
        tests++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL abort_stay: got %b expected 00", gnt); end
    endtask

    task automatic test_reset_midtransfer();
        tick(); dStb = 1; dWe = 0; dBe = 4'hF;
        tick(); sample();
        tests++; if ({gnt, mStb} !== 3'b101) begin errors++; $display("[TB] FAIL rstmid_pre: got %b expected 101", {gnt, mStb}); end
        @(posedge clk); #2; rst = 1'b1;
        #1;
        tests++; if ({gnt, mStb} !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_async: got %b expected 000", {gnt, mStb}); end
        dStb = 0; dBe = 0;
        @(negedge clk); rst = 1'b0;
        tick(); sample();
        tests++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_after: got %b expected 00", gnt); end
    endtask

`ifdef WB_MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit earlyAck = 0;
        bit lostGnt  = 0;
        tick(); iStb = 1; iAdr = 32'h0000_0400; mDatIn = 32'h1234_5678;
        for (int k = 1; k <= 8; k++) begin
            tick(); sample();
            if (iAck) earlyAck = 1;
            if (gnt != 2'b01) lostGnt = 1;
        end
        tests++; if ({earlyAck, lostGnt} !== 2'b00) begin errors++; $display("[TB] FAIL tmo_wait: got %b expected 00", {earlyAck, lostGnt}); end
        tick(); sample();
        tests++; if ({iAck, dAck} !== 2'b10) begin errors++; $display("[TB] FAIL tmo_ack: got %b expected 10", {iAck, dAck}); end
        tests++; if (iDat !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL tmo_data: got %h expected ffffffff", iDat); end
        tick(); iStb = 0; ackManual = 1;
        sample();
        tests++; if ({iAck, timeoutOut, gnt} !== 4'b0100) begin errors++; $display("[TB] FAIL tmo_late: got %b expected 0100", {iAck, timeoutOut, gnt}); end
        tick(); ackManual = 0;
        tick(); iStb = 1;
        tick(); ackManual = 1;
        sample();
        tests++; if ({iAck, timeoutOut} !== 2'b11) begin errors++; $display("[TB] FAIL tmo_next: got %b expected 11", {iAck, timeoutOut}); end
        tests++; if (iDat !== 32'h1234_5678) begin errors++; $display("[TB] FAIL tmo_nextdata: got %h expected 12345678", iDat); end
        tick(); ackManual = 0; iStb = 0; mDatIn = 0;
        tick();
    endtask
`else
    task automatic test_timeout();
        bit sawAck = 0;
        tick(); iStb = 1; iAdr = 32'h0000_0400;
        for (int k = 1; k <= 12; k++) begin
            tick(); sample();
            if (iAck) sawAck = 1;
        end
        tests++; if (sawAck !== 1'b0) begin errors++; $display("[TB] FAIL notmo_ack: got %b expected 0", sawAck); end
        tests++; if ({gnt, timeoutOut} !== 3'b010) begin errors++; $display("[TB] FAIL notmo_hold: got %b expected 010", {gnt, timeoutOut}); end
        tick(); iStb = 0;
        tick(); sample();
        tests++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL notmo_abort: got %b expected 00", gnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_imem_read();
        test_dmem_write();
        test_simultaneous();
        test_starvation();
        test_abort();
        test_reset_midtransfer();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
